instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter (PC) and issues single-outstanding read requests to instruction memory. It holds each returned 33-bit instruction in a one-entry output slot under a valid/ready handshake toward decode. It also applies PC-relative branch redirects from execute, and it squashes any stale or in-flight fetch when a redirect arrives.

## Interface
- INSTRUCTION_WIDTH, 33, instruction word width (from params.v)
- IMMEDIATE_WIDTH, 16, branch offset width, two's complement (from params.v)
- PC_WIDTH, 16, instruction-word address width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_enable  in  1  permits new requests; an outstanding request always completes
- imem_req  out  1  read request; held high until imem_ack
- imem_addr  out  PC_WIDTH  word address; stable while imem_req=1
- imem_ack  in  1  request completes this cycle; imem_rdata valid this cycle
- imem_rdata  in  INSTRUCTION_WIDTH  returned instruction
- instr_valid  out  1  output slot holds an instruction for decode
- instr_ready  in  1  decode accepts the slot this cycle
- instr_out  out  INSTRUCTION_WIDTH  instruction word to decoder
- instr_pc  out  PC_WIDTH  address of instr_out
- redirect_valid  in  1  taken branch; single-cycle pulse, highest priority
- redirect_base_pc  in  PC_WIDTH  address of the branch instruction
- redirect_offset  in  IMMEDIATE_WIDTH  signed branch offset

## Operation
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0.
- Slot frees this cycle when instr_valid=0, or when instr_valid=1 and instr_ready=1. A handshake clears instr_valid next cycle unless the slot is refilled.
- The PC advances as pc+1 mod 2^PC_WIDTH. At 0xFFFF it wraps to 0x0000.
- Redirect target = redirect_base_pc + 1 + sign_extend(redirect_offset), truncated to PC_WIDTH with wrap. Example: base 5, offset 0xFFFD gives target 3.
- FSM states are IDLE, REQ and DRAIN.
- IDLE: imem_req=0.
  - If fetch_enable=1, the slot frees this cycle and there is no redirect: imem_addr<=pc and the FSM moves to REQ.
- REQ: imem_req=1.
  - On imem_ack with no redirect: instr_out<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=pc+1, then IDLE.
- Redirect, any state:
  - pc<=target and instr_valid<=0 (slot squashed, even if instr_ready=1).
  - In IDLE: stay in IDLE.
  - In REQ with imem_ack the same cycle: discard imem_rdata, go to IDLE.
  - In REQ without ack: go to DRAIN.
- DRAIN: imem_req=1 with the old imem_addr unchanged.
  - On imem_ack: discard the data, go to IDLE.
  - A redirect in DRAIN overwrites pc with the newest target and stays in DRAIN, or goes to IDLE if ack arrives the same cycle.
- Only one request is ever outstanding, and the slot is always empty when an ack is accepted. No overflow case exists.
- fetch_enable=0 blocks only the IDLE to REQ transition.

## Timing
- imem_req and imem_addr are registered outputs. The first request is asserted on the 2nd rising edge after reset_n deasserts.
- imem_ack is accepted in any cycle with imem_req=1, including the first one (zero-wait memory).
- Fetch latency: instr_valid rises the cycle after the accepting ack.
- Peak throughput is 1 instruction per 2 cycles with zero-wait memory and instr_ready held at 1.
- A redirect takes effect at the next edge. The first target request is asserted 2 cycles after the redirect, or 1 cycle after the draining ack.
- Asserting reset_n mid-request drops all state immediately. Memory is required to abandon the transaction.

## Test plan
- Preload memory with 0x021000000, 0x022000000, 0x02300000A, 0x052210000 at addresses 0..3, zero-wait, instr_ready=1.
  - Required: instr_out shows those words in order with instr_pc 0,1,2,3.
  - Required: imem_req first rises 2 cycles after reset release, and instr_valid is high every other cycle.
- Backpressure: instr_ready=0 for 5 cycles with the slot full.
  - Required: instr_out is stable, imem_req stays 0, and no PC advance.
  - Required: releasing instr_ready issues address pc+1 the next cycle.
- Redirect in REQ with 3-cycle ack latency: redirect_base_pc=5, offset=0xFFFD.
  - Required: the FSM goes to DRAIN and the old request completes with its data discarded.
  - Required: the next request address is 3, and no stale instr_valid pulse appears.
- Redirect coincident with ack, and redirect while the slot is valid.
  - Required: both instructions are dropped and the next fetch is at the target.
  - Required: two redirects in DRAIN result in the second target being fetched.
- Wrap: RESET_PC=0xFFFF.
  - Required: instr_pc sequence is 0xFFFF then 0x0000.
  - Required: base 0x0000 with offset 0xFFFE gives target 0xFFFF.
- fetch_enable deasserted mid-request, then asynchronous reset mid-request.
  - Required: the pending request completes, then no new request is issued.
  - Required: reset forces imem_req=0 and instr_valid=0 immediately (asynchronous, before the next clock edge).

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack, the decode-side
// valid/ready slot, branch redirect from execute and the fetch enable.
`timescale 1ns/1ps
interface instruction_fetch_if #(
  parameter int INSTRUCTION_WIDTH = 33,
  parameter int IMMEDIATE_WIDTH   = 16,
  parameter int PC_WIDTH          = 16
);
  logic                         fetch_enable;
  logic                         imem_req;
  logic [PC_WIDTH-1:0]          imem_addr;
  logic                         imem_ack;
  logic [INSTRUCTION_WIDTH-1:0] imem_rdata;
  logic                         instr_valid;
  logic                         instr_ready;
  logic [INSTRUCTION_WIDTH-1:0] instr_out;
  logic [PC_WIDTH-1:0]          instr_pc;
  logic                         redirect_valid;
  logic [PC_WIDTH-1:0]          redirect_base_pc;
  logic [IMMEDIATE_WIDTH-1:0]   redirect_offset;

  // Fetch unit side
  modport master (
    input  fetch_enable,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr_out, instr_pc,
    input  redirect_valid, redirect_base_pc, redirect_offset
  );

  // Memory / decode / execute side
  modport slave (
    output fetch_enable,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr_out, instr_pc,
    output redirect_valid, redirect_base_pc, redirect_offset
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, keeps a single outstanding memory
// request, buffers the returned word in a one-entry slot for decode and
// squashes stale or in-flight fetches on a branch redirect.
`timescale 1ns/1ps
module instruction_fetch #(
  parameter int                  INSTRUCTION_WIDTH = 33,
  parameter int                  IMMEDIATE_WIDTH   = 16,
  parameter int                  PC_WIDTH          = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0
) (
  input logic                clk,
  input logic                reset_n,
  instruction_fetch_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int SUM_W = ((PC_WIDTH > IMMEDIATE_WIDTH) ? PC_WIDTH : IMMEDIATE_WIDTH) + 1;

  // base + 1 + sign_extend(offset), wrapped to the PC width
  function automatic logic [PC_WIDTH-1:0] branch_target(
    input logic        [PC_WIDTH-1:0]        base,
    input logic signed [IMMEDIATE_WIDTH-1:0] off
  );
    logic signed [SUM_W-1:0] base_ext;
    logic signed [SUM_W-1:0] off_ext;
    logic signed [SUM_W-1:0] sum;
    base_ext = SUM_W'(base);
    off_ext  = SUM_W'(off);
    sum      = base_ext + off_ext + SUM_W'(1);
    return sum[PC_WIDTH-1:0];
  endfunction

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pc;
  logic                started;
  logic                slot_free;
  logic [PC_WIDTH-1:0] target;

  assign slot_free = !bus.instr_valid || bus.instr_ready;
  assign target    = branch_target(bus.redirect_base_pc, bus.redirect_offset);

  // FSM, PC, registered memory request and the decode output slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      started         <= 1'b0;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= RESET_PC;
      bus.instr_valid <= 1'b0;
      bus.instr_out   <= '0;
      bus.instr_pc    <= '0;
    end else begin
      // One idle cycle after reset release before the first request goes out
      started <= 1'b1;

      if (bus.instr_valid && bus.instr_ready)
        bus.instr_valid <= 1'b0;

      if (bus.redirect_valid) begin
        pc              <= target;
        bus.instr_valid <= 1'b0;
        case (state)
          IDLE: state <= IDLE;
          REQ, DRAIN: begin
            // An in-flight request must still finish; its data is dropped
            if (bus.imem_ack) begin
              state        <= IDLE;
              bus.imem_req <= 1'b0;
            end else begin
              state        <= DRAIN;
            end
          end
          default: begin
            state        <= IDLE;
            bus.imem_req <= 1'b0;
          end
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (started && bus.fetch_enable && slot_free) begin
              bus.imem_addr <= pc;
              bus.imem_req  <= 1'b1;
              state         <= REQ;
            end
          end
          REQ: begin
            if (bus.imem_ack) begin
              bus.instr_out   <= bus.imem_rdata;
              bus.instr_pc    <= bus.imem_addr;
              bus.instr_valid <= 1'b1;
              pc              <= pc + PC_WIDTH'(1);
              bus.imem_req    <= 1'b0;
              state           <= IDLE;
            end
          end
          DRAIN: begin
            if (bus.imem_ack) begin
              bus.imem_req <= 1'b0;
              state        <= IDLE;
            end
          end
          default: begin
            bus.imem_req <= 1'b0;
            state        <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed stimulus pushes the
// expected (pc, word) pairs, a monitor pops them on every decode handshake.
`timescale 1ns/1ps
module tb_instruction_fetch;
  localparam int IW = 33;
  localparam int MW = 16;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  instruction_fetch_if #(.INSTRUCTION_WIDTH(IW), .IMMEDIATE_WIDTH(MW), .PC_WIDTH(PW)) bus ();
  instruction_fetch_if #(.INSTRUCTION_WIDTH(IW), .IMMEDIATE_WIDTH(MW), .PC_WIDTH(PW)) bus2 ();

  instruction_fetch #(.INSTRUCTION_WIDTH(IW), .IMMEDIATE_WIDTH(MW), .PC_WIDTH(PW),
                      .RESET_PC(16'h0000)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  instruction_fetch #(.INSTRUCTION_WIDTH(IW), .IMMEDIATE_WIDTH(MW), .PC_WIDTH(PW),
                      .RESET_PC(16'hFFFF)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] w;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int ack_lat = 0;
  int wait_cnt = 0;
  logic [PW-1:0] pc2_q[$];
  logic [IW-1:0] w2_q[$];

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    case (a)
      16'd0:   mem_word = 33'h021000000;
      16'd1:   mem_word = 33'h022000000;
      16'd2:   mem_word = 33'h02300000A;
      16'd3:   mem_word = 33'h052210000;
      default: mem_word = {1'b1, 16'h0000, a};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [PW-1:0] a);
    exp_t e;
    e.pc = a;
    e.w  = mem_word(a);
    sb.push_back(e);
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Wait for the current request to end and the next one to start, then check its address
  task automatic next_req(input string name, input logic [PW-1:0] a, input bit no_valid);
    int n;
    n = 0;
    while (bus.imem_req && n < 30) begin
      @(posedge clk); #1; n++;
      if (no_valid) chk({name, "_stale"}, bus.instr_valid, 0);
    end
    while (!bus.imem_req && n < 30) begin
      @(posedge clk); #1; n++;
      if (no_valid && !bus.imem_req) chk({name, "_stale"}, bus.instr_valid, 0);
    end
    if (n >= 30) timeout(name);
    else chk(name, bus.imem_addr, a);
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while ((bus.imem_req || bus.instr_valid || sb.size() != 0) && n < 40);
    if (n >= 40) timeout(name);
  endtask

  // Memory for dut: acks after ack_lat wait cycles
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req) begin
        if (wait_cnt >= ack_lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          wait_cnt       = 0;
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_rdata = '0;
          wait_cnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
      end
    end
  end

  // Scoreboard monitor: one pop per accepted (not squashed) slot
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got pc %h word %h expected none", bus.instr_pc, bus.instr_out);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", bus.instr_pc, e.pc);
          chk("sb_word", bus.instr_out, e.w);
        end
      end
    end
  end

  // dut2 environment: zero-wait memory returning the address, decode always ready
  initial begin
    bus2.fetch_enable     = 1'b1;
    bus2.instr_ready      = 1'b1;
    bus2.redirect_valid   = 1'b0;
    bus2.redirect_base_pc = '0;
    bus2.redirect_offset  = '0;
    bus2.imem_ack         = 1'b0;
    bus2.imem_rdata       = '0;
    forever begin
      @(negedge clk);
      bus2.imem_ack   = bus2.imem_req;
      bus2.imem_rdata = {17'h0, bus2.imem_addr};
      if (reset_n && bus2.instr_valid && pc2_q.size() < 2) begin
        pc2_q.push_back(bus2.instr_pc);
        w2_q.push_back(bus2.instr_out);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n              = 1'b0;
    bus.fetch_enable     = 1'b1;
    bus.instr_ready      = 1'b1;
    bus.redirect_valid   = 1'b0;
    bus.redirect_base_pc = '0;
    bus.redirect_offset  = '0;
    for (int i = 0; i < 4; i++) push(PW'(i));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_out", bus.instr_out, 0);
    chk("rst_pc", bus.instr_pc, 0);
    reset_n = 1'b1;

    // Streaming from addresses 0..3
    @(posedge clk); #1;
    chk("req_edge1", bus.imem_req, 0);
    @(posedge clk); #1;
    chk("req_edge2", bus.imem_req, 1);
    chk("addr_first", bus.imem_addr, 0);
    for (int k = 3; k <= 8; k++) begin
      @(posedge clk); #1;
      chk("valid_alt", bus.instr_valid, (k % 2 == 1) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1;
    chk("valid_pc3", bus.instr_valid, 1);
    chk("instr_pc3", bus.instr_pc, 3);

    // Backpressure
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_out", bus.instr_out, mem_word(16'd3));
      chk("bp_req", bus.imem_req, 0);
      chk("bp_valid", bus.instr_valid, 1);
    end
    bus.instr_ready = 1'b1;
    push(16'd4);
    @(posedge clk); #1;
    chk("bp_release_req", bus.imem_req, 1);
    chk("bp_release_addr", bus.imem_addr, 4);

    // Enable dropped while the request is outstanding
    bus.fetch_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("en_off_req", bus.imem_req, 0);
    end
    wait_quiet("en_off_quiet");

    // Redirect in REQ with 3-cycle ack latency: 5 + 1 - 3 = 3
    ack_lat = 2;
    bus.fetch_enable = 1'b1;
    @(posedge clk); #1;
    chk("rq_addr", bus.imem_addr, 5);
    bus.redirect_valid   = 1'b1;
    bus.redirect_base_pc = 16'd5;
    bus.redirect_offset  = 16'hFFFD;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    chk("drain_state", dut.state, 2);
    chk("drain_req", bus.imem_req, 1);
    chk("drain_addr", bus.imem_addr, 5);
    push(16'd3);
    next_req("redir_target", 16'd3, 1'b1);
    bus.fetch_enable = 1'b0;
    wait_quiet("redir_quiet");

    // Redirect coincident with ack, then redirect while the slot is valid
    ack_lat = 0;
    bus.fetch_enable = 1'b1;
    @(posedge clk); #1;
    chk("coinc_addr", bus.imem_addr, 4);
    bus.redirect_valid   = 1'b1;
    bus.redirect_base_pc = 16'h0010;
    bus.redirect_offset  = 16'h0005;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    chk("coinc_idle", bus.imem_req, 0);
    chk("coinc_valid", bus.instr_valid, 0);
    @(posedge clk); #1;
    chk("coinc_target", bus.imem_addr, 16'h0016);
    @(posedge clk); #1;
    chk("slot_pc", bus.instr_pc, 16'h0016);
    bus.redirect_valid   = 1'b1;
    bus.redirect_base_pc = 16'h0020;
    bus.redirect_offset  = 16'h0003;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    chk("squash_valid", bus.instr_valid, 0);
    push(16'h0024);
    @(posedge clk); #1;
    chk("squash_req", bus.imem_req, 1);
    chk("squash_target", bus.imem_addr, 16'h0024);
    bus.fetch_enable = 1'b0;
    wait_quiet("squash_quiet");

    // Two redirects while draining; the newest target wins
    ack_lat = 4;
    bus.fetch_enable = 1'b1;
    @(posedge clk); #1;
    chk("dr2_addr", bus.imem_addr, 16'h0025);
    bus.redirect_valid   = 1'b1;
    bus.redirect_base_pc = 16'h0040;
    bus.redirect_offset  = 16'h0000;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(posedge clk); #1;
    bus.redirect_valid   = 1'b1;
    bus.redirect_base_pc = 16'h0050;
    bus.redirect_offset  = 16'h0010;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    chk("dr2_hold_req", bus.imem_req, 1);
    chk("dr2_hold_addr", bus.imem_addr, 16'h0025);
    push(16'h0061);
    next_req("dr2_target", 16'h0061, 1'b1);
    bus.fetch_enable = 1'b0;
    wait_quiet("dr2_quiet");

    // Negative offset to 0xFFFF, then PC wrap to 0x0000
    ack_lat = 0;
    bus.redirect_valid   = 1'b1;
    bus.redirect_base_pc = 16'h0000;
    bus.redirect_offset  = 16'hFFFE;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    bus.fetch_enable   = 1'b1;
    push(16'hFFFF);
    push(16'h0000);
    @(posedge clk); #1;
    chk("wrap_target", bus.imem_addr, 16'hFFFF);
    next_req("wrap_addr0", 16'h0000, 1'b0);
    bus.fetch_enable = 1'b0;
    wait_quiet("wrap_quiet");

    // Asynchronous reset in the middle of a request
    ack_lat = 5;
    bus.fetch_enable = 1'b1;
    @(posedge clk); #1;
    chk("arst_pre_req", bus.imem_req, 1);
    chk("arst_pre_addr", bus.imem_addr, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_req", bus.imem_req, 0);
    chk("arst_valid", bus.instr_valid, 0);
    chk("arst_addr", bus.imem_addr, 0);
    @(posedge clk); #1;
    bus.fetch_enable = 1'b0;
    ack_lat = 0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    // RESET_PC = 0xFFFF instance
    chk("dut2_count", pc2_q.size(), 2);
    if (pc2_q.size() >= 2) begin
      chk("dut2_pc0", pc2_q[0], 16'hFFFF);
      chk("dut2_pc1", pc2_q[1], 16'h0000);
      chk("dut2_w0", w2_q[0], {17'h0, 16'hFFFF});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
